// File: rtl/hue_cycler.sv
// Hue/saturation/value animator: steps hue every N frames and pulses brightness
// between v_min and v_max, feeding an HSV-to-RGB converter.
//
// state | meaning
// HOLD  | v parked at v_max; pulse disabled or bounds degenerate
// RISE  | v climbing by V_STEP toward v_max
// FALL  | v descending by V_STEP toward v_min
module hue_cycler #(
  parameter int V_STEP   = 4,
  parameter int HUE_WRAP = 360
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       en,
  input  logic [3:0] hue_step,
  input  logic [5:0] frames_per_step,
  input  logic       pulse_en,
  input  logic [7:0] v_min,
  input  logic [7:0] v_max,
  input  logic [7:0] s_in,
  input  logic       load,
  input  logic [8:0] load_hue,
  output logic [8:0] h,
  output logic [7:0] s,
  output logic [7:0] v,
  output logic       hsv_valid
);

  typedef enum logic [1:0] {HOLD, RISE, FALL} vstate_e;

  localparam logic [8:0] WRAP9 = 9'(HUE_WRAP);
  localparam logic [8:0] STEP9 = 9'(V_STEP);
  localparam logic [7:0] STEP8 = 8'(V_STEP);

  vstate_e    state_q;
  logic [5:0] div_q;
  logic [8:0] h_q;
  logic [7:0] s_q;
  logic [7:0] v_q;
  logic       hsv_valid_q;

  logic       tick_en;
  logic       advance;
  logic       pulse_ok;
  logic [5:0] limit_m1;
  logic [8:0] h_sum;
  logic [8:0] h_adv_d;
  logic [8:0] h_load_d;
  logic [8:0] v_sum;
  logic [7:0] v_rise_d;
  logic [7:0] v_fall_d;

  // ">=" rather than "==" so a divider shortened mid-count still advances promptly
  assign limit_m1 = (frames_per_step == 6'd0) ? 6'd0 : frames_per_step - 6'd1;
  assign tick_en  = en & frame_tick;
  assign advance  = tick_en & (div_q >= limit_m1);
  assign pulse_ok = pulse_en & (v_min < v_max);

  assign h_sum    = h_q + {5'd0, hue_step};
  assign h_adv_d  = (h_sum >= WRAP9) ? h_sum - WRAP9 : h_sum;
  assign h_load_d = (load_hue >= WRAP9) ? load_hue - WRAP9 : load_hue;

  assign v_sum    = {1'b0, v_q} + STEP9;
  assign v_rise_d = (v_sum >= {1'b0, v_max}) ? v_max : v_sum[7:0];
  assign v_fall_d = ({1'b0, v_q} >= ({1'b0, v_min} + STEP9)) ? v_q - STEP8 : v_min;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      div_q       <= 6'd0;
      h_q         <= 9'd0;
      s_q         <= 8'd0;
      v_q         <= 8'd0;
      hsv_valid_q <= 1'b0;
    end else begin
      hsv_valid_q <= load | advance;

      if (load) begin
        h_q   <= h_load_d;
        s_q   <= s_in;
        div_q <= 6'd0;
      end else if (tick_en) begin
        div_q <= advance ? 6'd0 : div_q + 6'd1;
        if (advance) begin
          h_q <= h_adv_d;
          s_q <= s_in;
        end
      end

      // Brightness moves only on an advance, even when a load shares the cycle
      if (advance) begin
        if (!pulse_ok) begin
          state_q <= HOLD;
          v_q     <= v_max;
        end else begin
          unique case (state_q)
            HOLD: begin
              state_q <= RISE;
              v_q     <= v_min;
            end
            RISE: begin
              v_q <= v_rise_d;
              if (v_rise_d == v_max) state_q <= FALL;
            end
            FALL: begin
              v_q <= v_fall_d;
              if (v_fall_d == v_min) state_q <= RISE;
            end
            default: begin
              state_q <= HOLD;
              v_q     <= v_max;
            end
          endcase
        end
      end
    end
  end

  assign h         = h_q;
  assign s         = s_q;
  assign v         = v_q;
  assign hsv_valid = hsv_valid_q;

endmodule

// File: tb/tb_hue_cycler.sv
// Directed bench for hue_cycler: divider, hue wrap, brightness pulse, load and reset.
module tb_hue_cycler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       en;
  logic [3:0] hue_step;
  logic [5:0] frames_per_step;
  logic       pulse_en;
  logic [7:0] v_min;
  logic [7:0] v_max;
  logic [7:0] s_in;
  logic       load;
  logic [8:0] load_hue;
  logic [8:0] h;
  logic [7:0] s;
  logic [7:0] v;
  logic       hsv_valid;

  int checks = 0;
  int errors = 0;

  hue_cycler #(.V_STEP(4), .HUE_WRAP(360)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .en(en),
    .hue_step(hue_step), .frames_per_step(frames_per_step), .pulse_en(pulse_en),
    .v_min(v_min), .v_max(v_max), .s_in(s_in), .load(load), .load_hue(load_hue),
    .h(h), .s(s), .v(v), .hsv_valid(hsv_valid)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: advance one edge and leave the bench 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_load(input logic [8:0] hue);
    load_hue = hue;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b1; en = 1'b1; load = 1'b1; load_hue = 9'd77;
    hue_step = 4'd3; frames_per_step = 6'd1; pulse_en = 1'b0;
    v_min = 8'd0; v_max = 8'd200; s_in = 8'd9;
    step(); step();
    frame_tick = 1'b0; load = 1'b0;
    checks++;
    if ({h, s, v, hsv_valid} !== 26'd0) begin
      errors++;
      $display("FAIL reset: h=%0d s=%0d v=%0d valid=%0b, want all 0", h, s, v, hsv_valid);
    end
  endtask

  task automatic test_divider();
    rst_n = 1'b1; en = 1'b1; frames_per_step = 6'd3; hue_step = 4'd10;
    pulse_en = 1'b0; v_max = 8'd200; s_in = 8'd255;
    step();
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (hsv_valid !== 1'b0) begin
        errors++;
        $display("FAIL div_early tick%0d: valid=%0b want 0", i, hsv_valid);
      end
      step();
    end
    tick();
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd10 || s !== 8'd255 || v !== 8'd200) begin
      errors++;
      $display("FAIL div_adv: valid=%0b h=%0d s=%0d v=%0d want 1/10/255/200", hsv_valid, h, s, v);
    end
    step();
    checks++;
    if (hsv_valid !== 1'b0) begin
      errors++;
      $display("FAIL div_pulse_width: valid=%0b want 0", hsv_valid);
    end
  endtask

  task automatic test_load_wrap();
    s_in = 8'd128;
    do_load(9'd355);
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd355 || s !== 8'd128 || v !== 8'd200) begin
      errors++;
      $display("FAIL load355: valid=%0b h=%0d s=%0d v=%0d want 1/355/128/200", hsv_valid, h, s, v);
    end
    frames_per_step = 6'd1; hue_step = 4'd10;
    tick();
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd5) begin
      errors++;
      $display("FAIL hue_wrap: valid=%0b h=%0d want 1/5", hsv_valid, h);
    end
    do_load(9'd400);
    checks++;
    if (h !== 9'd40) begin
      errors++;
      $display("FAIL load400: h=%0d want 40", h);
    end
  endtask

  task automatic test_pulse();
    int exp_v[8] = '{0, 4, 8, 10, 6, 2, 0, 4};
    hue_step = 4'd0; v_min = 8'd0; v_max = 8'd10; pulse_en = 1'b1; frames_per_step = 6'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (hsv_valid !== 1'b1 || v !== 8'(exp_v[i]) || h !== 9'd40) begin
        errors++;
        $display("FAIL pulse[%0d]: valid=%0b v=%0d h=%0d want 1/%0d/40", i, hsv_valid, v, h, exp_v[i]);
      end
    end
  endtask

  task automatic test_equal_bounds_and_freeze();
    v_min = 8'd50; v_max = 8'd50;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (v !== 8'd50 || hsv_valid !== 1'b1) begin
        errors++;
        $display("FAIL eq_bounds[%0d]: v=%0d valid=%0b want 50/1", i, v, hsv_valid);
      end
    end
    en = 1'b0; hue_step = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hsv_valid !== 1'b0) begin
        errors++;
        $display("FAIL freeze_valid[%0d]: valid=%0b want 0", i, hsv_valid);
      end
    end
    checks++;
    if (h !== 9'd40 || v !== 8'd50) begin
      errors++;
      $display("FAIL freeze_hold: h=%0d v=%0d want 40/50", h, v);
    end
    do_load(9'd123);
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd123) begin
      errors++;
      $display("FAIL freeze_load: valid=%0b h=%0d want 1/123", hsv_valid, h);
    end
    en = 1'b1;
  endtask

  task automatic test_load_advance();
    pulse_en = 1'b0; v_max = 8'd77; hue_step = 4'd5; frames_per_step = 6'd2;
    do_load(9'd100);
    tick();
    checks++;
    if (hsv_valid !== 1'b0) begin
      errors++;
      $display("FAIL la_pre: valid=%0b want 0", hsv_valid);
    end
    load_hue = 9'd200; load = 1'b1; frame_tick = 1'b1;
    step();
    load = 1'b0; frame_tick = 1'b0;
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd200 || v !== 8'd77) begin
      errors++;
      $display("FAIL la_same: valid=%0b h=%0d v=%0d want 1/200/77", hsv_valid, h, v);
    end
    step();
    checks++;
    if (hsv_valid !== 1'b0) begin
      errors++;
      $display("FAIL la_single: valid=%0b want 0", hsv_valid);
    end
    tick();
    checks++;
    if (hsv_valid !== 1'b0) begin
      errors++;
      $display("FAIL la_div_cleared: valid=%0b want 0", hsv_valid);
    end
    tick();
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd205) begin
      errors++;
      $display("FAIL la_next: valid=%0b h=%0d want 1/205", hsv_valid, h);
    end
  endtask

  task automatic test_fps_change();
    frames_per_step = 6'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hsv_valid !== 1'b0) begin
        errors++;
        $display("FAIL fps5[%0d]: valid=%0b want 0", i, hsv_valid);
      end
    end
    frames_per_step = 6'd2;
    tick();
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd210) begin
      errors++;
      $display("FAIL fps_shrink: valid=%0b h=%0d want 1/210", hsv_valid, h);
    end
    tick();
    tick();
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd215) begin
      errors++;
      $display("FAIL fps_resume: valid=%0b h=%0d want 1/215", hsv_valid, h);
    end
  endtask

  task automatic test_reset_mid();
    frames_per_step = 6'd4;
    tick(); tick();
    rst_n = 1'b0; frame_tick = 1'b1; load = 1'b1; load_hue = 9'd300;
    step();
    frame_tick = 1'b0; load = 1'b0;
    checks++;
    if ({h, s, v, hsv_valid} !== 26'd0) begin
      errors++;
      $display("FAIL reset_mid: h=%0d s=%0d v=%0d valid=%0b want all 0", h, s, v, hsv_valid);
    end
    rst_n = 1'b1; s_in = 8'd33;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hsv_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_recount[%0d]: valid=%0b want 0", i, hsv_valid);
      end
    end
    tick();
    checks++;
    if (hsv_valid !== 1'b1 || h !== 9'd5 || s !== 8'd33 || v !== 8'd77) begin
      errors++;
      $display("FAIL reset_first_adv: valid=%0b h=%0d s=%0d v=%0d want 1/5/33/77", hsv_valid, h, s, v);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_load_wrap();
    test_pulse();
    test_equal_bounds_and_freeze();
    test_load_advance();
    test_fps_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
